// File: rtl/alarm_bank_if.sv
// Button/switch inputs and alarm bank outputs of the alarm bank editor.
// The master drives the buttons; the slave is the editor.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4,
  parameter int NUM_DIGITS = 4
);
  localparam int SW = $clog2(NUM_ALARMS);
  localparam int W  = 4 * NUM_DIGITS;

  logic                       edit_en;
  logic                       btn_u;
  logic                       btn_d;
  logic                       btn_l;
  logic                       btn_r;
  logic                       btn_c;
  logic [NUM_DIGITS-1:0]      sel;
  logic [SW-1:0]              slot;
  logic [W-1:0]               shadow;
  logic [W*NUM_ALARMS-1:0]    alarm_flat;
  logic [NUM_ALARMS-1:0]      alarm_valid;
  logic                       done;

  modport master (
    output edit_en, btn_u, btn_d, btn_l, btn_r, btn_c,
    input  sel, slot, shadow, alarm_flat, alarm_valid, done
  );

  modport slave (
    input  edit_en, btn_u, btn_d, btn_l, btn_r, btn_c,
    output sel, slot, shadow, alarm_flat, alarm_valid, done
  );
endinterface

// File: rtl/alarm_bank_editor.sv
// Multi-slot BCD alarm editor with shadow register and hold-to-repeat.
// Optional ALARM_CLEAR_EN: holding up+down zeroes the slot and clears valid.
module alarm_bank_editor #(
  parameter int NUM_ALARMS   = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic clk,
  input  logic resetn,
  alarm_bank_if.slave bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int SW = $clog2(NUM_ALARMS);
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] C_RLD = CW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [NUM_DIGITS-1:0] SEL_MSB = {1'b1, {(NUM_DIGITS-1){1'b0}}};
  localparam logic [SW-1:0] LAST = SW'(NUM_ALARMS - 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  state_t state, state_nx;

  logic [4:0]            raw, bq, bq2, ev;
  logic [CW-1:0]         cnt [2];
  logic [W-1:0]          bank [NUM_ALARMS];
  logic [W-1:0]          shadow, edited;
  logic [NUM_DIGITS-1:0] sel, moved;
  logic [SW-1:0]         slot, slot_nx;
  logic [NUM_ALARMS-1:0] valid;
  logic                  done;
  logic                  load, commit, act, adv;
  logic                  inc, dec, mv_l, mv_r;
  logic [3:0]            dg, mx;
  logic                  clr_hit, clr_pend;

  // bit order {c, r, l, d, u}
  assign raw = {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bq  <= '0;
      bq2 <= '0;
    end else begin
      bq  <= raw;
      bq2 <= bq;
    end
  end

  // cnt = cycles since the rising-edge event; reload keeps the rate period
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn || !bq[i])   cnt[i] <= '0;
      else if (!bq2[i])        cnt[i] <= CW'(1);
      else if (cnt[i] == C_DLY) cnt[i] <= C_RLD;
      else                     cnt[i] <= cnt[i] + 1'b1;
    end
  end

  always_comb begin
    ev = bq & ~bq2;
    for (int i = 0; i < 2; i++)
      if (bq[i] && bq2[i] && cnt[i] == C_DLY) ev[i] = 1'b1;
    if (state != EDIT) ev = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.edit_en) state_nx = EDIT;
      EDIT:    if (!bus.edit_en) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    act    = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE:    load   = bus.edit_en;
      EDIT:    act    = bus.edit_en;
      COMMIT:  commit = 1'b1;
      default: ;
    endcase
  end

  assign adv  = act & ev[4];
  assign inc  = act & ~ev[4] & ev[0] & ~ev[1];
  assign dec  = act & ~ev[4] & ev[1] & ~ev[0];
  assign mv_l = act & ~ev[4] & ev[2] & ~ev[3];
  assign mv_r = act & ~ev[4] & ev[3] & ~ev[2];
  assign slot_nx = (slot == LAST) ? '0 : slot + 1'b1;

  always_comb begin
    edited = shadow;
    moved  = sel;
    dg     = '0;
    mx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) begin
        dg = shadow[4*i +: 4];
        mx = (i % 2 == 1) ? 4'd5 : 4'd9;
        if (inc)      edited[4*i +: 4] = (dg == mx) ? 4'd0 : dg + 4'd1;
        else if (dec) edited[4*i +: 4] = (dg == 4'd0) ? mx : dg - 4'd1;
      end
    end
    if (mv_l)      moved = {sel[NUM_DIGITS-2:0], sel[NUM_DIGITS-1]};
    else if (mv_r) moved = {sel[0], sel[NUM_DIGITS-1:1]};
  end

`ifdef ALARM_CLEAR_EN
  logic [CW-1:0] ud_cnt;
  logic          ud_armed;

  assign clr_hit = act && bq[0] && bq[1] && ud_armed &&
                   (ud_cnt == C_DLY - 1'b1);

  always_ff @(posedge clk) begin
    if (!resetn || !(bq[0] && bq[1]) || state != EDIT) begin
      ud_cnt   <= '0;
      ud_armed <= 1'b1;
    end else if (clr_hit) begin
      ud_armed <= 1'b0;
    end else if (ud_armed) begin
      ud_cnt   <= ud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || commit || adv) clr_pend <= 1'b0;
    else if (clr_hit && !adv)     clr_pend <= 1'b1;
  end
`else
  assign clr_hit  = 1'b0;
  assign clr_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel    <= '0;
      slot   <= '0;
      shadow <= '0;
      valid  <= '0;
      done   <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) bank[k] <= '0;
    end else begin
      done <= commit | adv;
      if (commit || adv) begin
        bank[slot]  <= shadow;
        valid[slot] <= ~clr_pend;
      end
      if (load) begin
        shadow <= bank[slot];
        sel    <= SEL_MSB;
      end else if (adv) begin
        slot   <= slot_nx;
        shadow <= bank[slot_nx];
        sel    <= SEL_MSB;
      end else if (commit) begin
        sel    <= '0;
      end else if (act) begin
        shadow <= clr_hit ? '0 : edited;
        sel    <= moved;
      end
    end
  end

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_flat
    assign bus.alarm_flat[k*W +: W] = bank[k];
  end

  assign bus.sel         = sel;
  assign bus.slot        = slot;
  assign bus.shadow      = shadow;
  assign bus.alarm_valid = valid;
  assign bus.done        = done;
endmodule

// File: doc/alarm_bank_editor.md
Name: alarm_bank_editor

Overview:
- Parametrised multi-slot alarm editor: holds NUM_ALARMS alarm times, each NUM_DIGITS BCD digits in mm:ss-style format.
- Edits one slot through a shadow register using up/down/left/right buttons, with per-digit wrap limits and hold-to-repeat on up/down.
- Commits the shadow to the bank on exit or slot advance.
- Sits between the debounced button/switch front end and the alarm compare and display blocks.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (2..8).
- NUM_DIGITS, 4, BCD digits per slot (even, 2..8). Digit 0 is rightmost.
- REPEAT_DELAY, 50000000, cycles an up/down button must be held before auto-repeat starts.
- REPEAT_RATE, 10000000, cycles between auto-repeat events once repeating.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- edit_en  in  1  edit-mode switch level (debounced)
- btn_u / btn_d  in  1 each  increment / decrement level (debounced)
- btn_l / btn_r  in  1 each  cursor left / right level (debounced)
- btn_c  in  1  commit-and-next-slot level (debounced)
- sel  out  NUM_DIGITS  one-hot cursor digit for display blink
- slot  out  $clog2(NUM_ALARMS)  slot currently edited or last edited
- shadow  out  4*NUM_DIGITS  working copy being edited
- alarm_flat  out  4*NUM_DIGITS*NUM_ALARMS  committed bank; slot k at [k*4*NUM_DIGITS +: 4*NUM_DIGITS]
- alarm_valid  out  NUM_ALARMS  bit k set once slot k has been committed
- done  out  1  one-cycle pulse per commit

Behaviour:
- Reset values:
  - sel=0, slot=0, shadow=0, alarm_flat=0, alarm_valid=0, done=0
  - FSM=IDLE; repeat counters and edge registers cleared.
- Edge detect: all buttons are registered internally. An event is the rising edge of the level (1 cycle after the input rises). No events are generated in IDLE.
- Auto-repeat, btn_u/btn_d only:
  - While the same button stays high, the counter starts at its edge.
  - After REPEAT_DELAY cycles the button emits an event, then one event every REPEAT_RATE cycles.
  - Release resets the counter.
- FSM states:
  - IDLE: sel=0. On edit_en=1, load shadow from the slot's bank entry, set sel to MSB (digit NUM_DIGITS-1), and go to EDIT.
  - EDIT: process events; on edit_en=0 go to COMMIT.
  - COMMIT: one cycle. Write shadow to the slot, set alarm_valid[slot], pulse done, set sel=0, go to IDLE.
- btn_c event in EDIT (only valid while edit_en=1):
  - Same-cycle write of shadow to the bank; set valid bit; pulse done.
  - slot = (slot==NUM_ALARMS-1) ? 0 : slot+1.
  - Reload shadow from the new slot next cycle; cursor returns to MSB.
  - Stays in EDIT.
- Digit limits: digit i has max 5 if i is odd, otherwise 9.
  - Up: max wraps to 0, else +1.
  - Down: 0 wraps to max, else -1.
  - No carry or borrow into neighbouring digits.
- Cursor:
  - Left shifts sel toward the MSB; MSB wraps to LSB.
  - Right shifts sel toward the LSB; LSB wraps to MSB.
  - Always exactly one bit set in EDIT.
- Simultaneous events:
  - u+d in the same cycle: both ignored.
  - l+r in the same cycle: both ignored.
  - Value event plus cursor event: the value applies to the digit selected before the move.
  - btn_c event with any other event: the other events are ignored.
  - edit_en falling with any event: events are ignored and the FSM goes to COMMIT.
- Loaded shadow values are never out of range: the bank only ever receives in-range values.
- Reset mid-edit: the shadow is discarded, all state returns to reset values, and no done pulse is generated.
- Latency: button edge to shadow/sel update is 2 clk after the input rises.

Optional Feature:
- Macro: ALARM_CLEAR_EN.
- Defined:
  - In EDIT, btn_u and btn_d both high for REPEAT_DELAY consecutive cycles zeroes the shadow.
  - On the next commit, that slot's alarm_valid bit is cleared instead of set, and done still pulses.
  - The clear is armed once per hold.
- Undefined: u+d held together stays ignored; commit always sets valid.

Test Plan:
- NUM_ALARMS=2, NUM_DIGITS=4, REPEAT_DELAY=8, REPEAT_RATE=4. Reset, then edit_en=1 -> sel=4'b1000, shadow=16'h0000. Pulse btn_u 3 times -> shadow=16'h3000. edit_en=0 -> done pulses once, alarm_flat[15:0]=16'h3000, alarm_valid=2'b01.
- Limits: cursor to digit 2 (btn_r once) and press btn_d once -> digit 2 = 9. Cursor to digit 1 and press btn_d -> digit 1 = 5. Press btn_u -> 0. Btn_r from digit 0 -> sel=4'b1000.
- Auto-repeat: hold btn_u for 20 cycles on digit 0 from 0 -> events at edge, +8, +12, +16, +20. Digit = 5, and stays 5 after release.
- Slot advance: in EDIT with shadow=16'h1234, press btn_c -> done pulse, slot0=16'h1234, slot=1, shadow reloads 16'h0000. A second btn_c -> slot wraps to 0 and shadow reloads 16'h1234.
- Simultaneous: btn_u+btn_d in the same cycle -> no change. btn_u+btn_l in the same cycle on digit 0 -> digit 0 increments, sel moves to digit 1.
- Reset mid-edit: edit slot0 to 16'h0500, assert resetn=0 before edit_en falls -> alarm_flat=0, alarm_valid=0, done never pulses.
